// File: rtl/lif_neuron_stdp.sv
// rtl/lif_neuron_stdp.sv - leaky integrate-and-fire neuron with refractory hold
//
// Purpose: each integrating cycle adds the signed synaptic current, the static
// bias and the dynamic bias to the stored potential, subtracts the leak, clamps
// the result to [0, 2^POTENTIAL_WIDTH-1] and fires when it reaches THRESHOLD.
// A firing event clears the potential and optionally starts a refractory hold.
//
// Ports:
//   clk                 in   1                  rising-edge clock
//   rst_n               in   1                  synchronous active-low reset
//   input_current       in   POTENTIAL_WIDTH+1  signed synaptic current
//   bias_signal         in   4                  signed dynamic bias (-8..+7)
//   spike_out           out  1                  registered one-cycle spike
//   membrane_potential  out  POTENTIAL_WIDTH    registered potential, unsigned

module lif_neuron_stdp #(
  parameter int THRESHOLD       = 20,
  parameter int LEAK            = 1,
  parameter int BIAS            = 0,
  parameter int POTENTIAL_WIDTH = 8,
  parameter int REFRACTORY      = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [POTENTIAL_WIDTH:0]   input_current,
  input  logic [3:0]                 bias_signal,
  output logic                       spike_out,
  output logic [POTENTIAL_WIDTH-1:0] membrane_potential
);

  localparam int PW = POTENTIAL_WIDTH;
  // Six guard bits absorb the worst-case sum of four terms without overflow.
  localparam int SW = PW + 6;
  localparam int CW = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  localparam logic signed [SW-1:0] BIAS_S  = SW'(BIAS);
  localparam logic signed [SW-1:0] LEAK_S  = SW'(LEAK);
  localparam logic signed [SW-1:0] POT_MAX = SW'((2 ** PW) - 1);

  // A threshold above the largest storable potential can never be reached,
  // so firing is disabled outright rather than comparing truncated values.
  localparam bit              FIRE_EN = (THRESHOLD <= ((2 ** PW) - 1));
  localparam logic [PW-1:0]   THR_W   = FIRE_EN ? PW'(THRESHOLD) : '0;
  localparam logic [CW-1:0]   REFR_W  = CW'(REFRACTORY);

  logic [PW-1:0]        pot;
  logic [CW-1:0]        refr_cnt;

  logic signed [SW-1:0] pot_ext;
  logic signed [SW-1:0] cur_ext;
  logic signed [SW-1:0] dyn_ext;
  logic signed [SW-1:0] sum;
  logic [PW-1:0]        clamped;
  logic                 fire;

  always_comb begin
    pot_ext = {{(SW-PW){1'b0}}, pot};
    cur_ext = {{(SW-PW-1){input_current[PW]}}, input_current};
    dyn_ext = {{(SW-4){bias_signal[3]}}, bias_signal};
    sum     = pot_ext + cur_ext + BIAS_S + dyn_ext - LEAK_S;

    clamped = '0;
    if (sum[SW-1]) begin
      clamped = '0;
    end else if (sum > POT_MAX) begin
      clamped = '1;
    end else begin
      clamped = sum[PW-1:0];
    end

    fire = FIRE_EN && (clamped >= THR_W);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pot       <= '0;
      spike_out <= 1'b0;
      refr_cnt  <= '0;
    end else if (refr_cnt != '0) begin
      // Refractory: inputs ignored, potential pinned at zero.
      pot       <= '0;
      spike_out <= 1'b0;
      refr_cnt  <= refr_cnt - 1'b1;
    end else if (fire) begin
      pot       <= '0;
      spike_out <= 1'b1;
      refr_cnt  <= REFR_W;
    end else begin
      pot       <= clamped;
      spike_out <= 1'b0;
    end
  end

  assign membrane_potential = pot;

endmodule

// File: tb/tb_lif_neuron_stdp.sv
// tb/tb_lif_neuron_stdp.sv - directed scoreboard bench for lif_neuron_stdp

module tb_lif_neuron_stdp;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] input_current = '0;
  logic [3:0] bias_signal = '0;

  logic       spk_def, spk_sat, spk_ref;
  logic [7:0] pot_def, pot_sat, pot_ref;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         sel;
    logic       spk;
    logic [7:0] pot;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lif_neuron_stdp u_def (
    .clk(clk), .rst_n(rst_n), .input_current(input_current),
    .bias_signal(bias_signal), .spike_out(spk_def), .membrane_potential(pot_def)
  );

  lif_neuron_stdp #(.THRESHOLD(1000)) u_sat (
    .clk(clk), .rst_n(rst_n), .input_current(input_current),
    .bias_signal(bias_signal), .spike_out(spk_sat), .membrane_potential(pot_sat)
  );

  lif_neuron_stdp #(.REFRACTORY(2)) u_ref (
    .clk(clk), .rst_n(rst_n), .input_current(input_current),
    .bias_signal(bias_signal), .spike_out(spk_ref), .membrane_potential(pot_ref)
  );

  task automatic check_head();
    exp_t       e;
    logic [8:0] obs;
    e = sb.pop_front();
    case (e.sel)
      0:       obs = {spk_def, pot_def};
      1:       obs = {spk_sat, pot_sat};
      default: obs = {spk_ref, pot_ref};
    endcase
    checks++;
    assert (obs === {e.spk, e.pot})
    else begin
      errors++;
      $error("FAIL %s: observed spike=%0d pot=%0d expected spike=%0d pot=%0d",
             e.tag, obs[8], obs[7:0], e.spk, e.pot);
    end
  endtask

  // Drive one cycle of stimulus, queue the expectation, sample after the edge.
  task automatic step(input logic r, input int cur, input int b, input int sel,
                      input logic es, input int ep, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n         = r;
    input_current = 9'(cur);
    bias_signal   = 4'(b);
    e.tag = tag; e.sel = sel; e.spk = es; e.pot = 8'(ep);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_head();
  endtask

  initial begin
    // Reset state on all three instances
    step(0, 0, 0, 0, 0, 0, "rst_def");
    step(0, 0, 0, 0, 0, 0, "rst_def2");
    step(0, 0, 0, 1, 0, 0, "rst_sat");
    step(0, 0, 0, 2, 0, 0, "rst_ref");

    // Reset mid-integration
    step(1, 6, 0, 0, 0, 5,  "int_a");
    step(1, 6, 0, 0, 0, 10, "int_b");
    step(0, 6, 0, 0, 0, 0,  "mid_rst");
    step(1, 6, 0, 0, 0, 5,  "resume");

    // Integrate and fire, repeating every 4 cycles
    step(1, 6, 0, 0, 0, 10, "if_10");
    step(1, 6, 0, 0, 0, 15, "if_15");
    step(1, 6, 0, 0, 1, 0,  "fire1");
    step(1, 6, 0, 0, 0, 5,  "if2_5");
    step(1, 6, 0, 0, 0, 10, "if2_10");
    step(1, 6, 0, 0, 0, 15, "if2_15");
    step(1, 6, 0, 0, 1, 0,  "fire2");

    // Leak down to the floor
    step(1, 6, 0, 0, 0, 5, "lk_5");
    step(1, 0, 0, 0, 0, 4, "lk_4");
    step(1, 0, 0, 0, 0, 3, "lk_3");
    step(1, 0, 0, 0, 0, 2, "lk_2");
    step(1, 0, 0, 0, 0, 1, "lk_1");
    step(1, 0, 0, 0, 0, 0, "lk_0");
    step(1, 0, 0, 0, 0, 0, "lk_floor");

    // Negative current clamps to zero
    step(1, 6,  0, 0, 0, 5, "neg_pre");
    step(1, -9, 0, 0, 0, 0, "neg_clamp");

    // Dynamic bias
    step(1, 0, 5, 0, 0, 4,  "db_4");
    step(1, 0, 5, 0, 0, 8,  "db_8");
    step(1, 0, 5, 0, 0, 12, "db_12");
    step(1, 0, 5, 0, 0, 16, "db_16");
    step(1, 0, 5, 0, 1, 0,  "db_fire");
    step(1, 0, 8, 0, 0, 0,  "db_neg8");
    step(1, 0, 8, 0, 0, 0,  "db_neg8b");
    step(1, 3, 7, 0, 0, 9,  "db_pos7");

    // Saturation, threshold unreachable
    step(0, 0,   0, 1, 0, 0,   "sat_rst");
    step(1, 200, 0, 1, 0, 199, "sat_199");
    step(1, 200, 0, 1, 0, 255, "sat_255");
    step(1, 200, 0, 1, 0, 255, "sat_hold");
    step(1, 200, 0, 1, 0, 255, "sat_hold2");

    // Refractory hold
    step(0, 0,  0, 2, 0, 0, "ref_rst");
    step(1, 30, 0, 2, 1, 0, "ref_fire1");
    step(1, 30, 0, 2, 0, 0, "ref_hold1");
    step(1, 30, 0, 2, 0, 0, "ref_hold2");
    step(1, 30, 0, 2, 1, 0, "ref_fire2");
    step(1, 30, 0, 2, 0, 0, "ref_hold3");
    step(0, 30, 0, 2, 0, 0, "ref_rst_mid");
    step(1, 30, 0, 2, 1, 0, "ref_fire3");

    // Consecutive firing without refractory
    step(1, 30, 0, 0, 1, 0, "cons_a");
    step(1, 30, 0, 0, 1, 0, "cons_b");

    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL sb_drain: observed %0d expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lif_neuron_stdp.md
Name: lif_neuron_stdp

Overview:
Single leaky integrate-and-fire neuron. It is the basic processing element of the SNN core, instantiated for both the hidden and the output layers. Each cycle it integrates a signed synaptic current plus static and dynamic bias, subtracts a leak, and compares the result with a threshold. On reaching the threshold it emits a one-cycle spike and resets its potential. The membrane potential is exported for debug.

Parameters:
THRESHOLD  20  firing threshold, unsigned integer, compared against post-leak potential
LEAK  1  constant subtracted every integrating cycle, integer >= 0
BIAS  0  static signed integer added every integrating cycle
POTENTIAL_WIDTH  8  width of the stored, unsigned membrane potential
REFRACTORY  0  cycles after a spike during which the neuron ignores input and holds potential at 0

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  reset; synchronous, active-low
input_current  in  POTENTIAL_WIDTH+1  signed synaptic current for this cycle (two's complement)
bias_signal  in  4  signed dynamic bias, -8..+7, sign-extended before use
spike_out  out  1  registered spike pulse
membrane_potential  out  POTENTIAL_WIDTH  registered current potential, unsigned

Behaviour:
- Reset: when rst_n=0 at a clk edge, the following are cleared on that edge:
  - potential = 0, spike_out = 0, refractory counter = 0.
  - Reset has priority over everything, including mid-integration and mid-refractory.
- Integrating cycle (refractory counter = 0):
  - sum = pot + sext(input_current) + BIAS + sext(bias_signal) - LEAK.
  - Compute in a signed intermediate at least POTENTIAL_WIDTH+6 bits wide; no intermediate overflow is permitted.
- Clamping:
  - sum < 0 -> 0.
  - sum > 2^POTENTIAL_WIDTH-1 -> 2^POTENTIAL_WIDTH-1 (saturate; never wrap).
- Firing:
  - If clamped sum >= THRESHOLD: spike_out <= 1, pot <= 0, refractory counter <= REFRACTORY.
  - Otherwise: spike_out <= 0, pot <= clamped sum.
- Refractory cycle (counter > 0):
  - Inputs are ignored, pot held at 0, spike_out <= 0, counter decrements by 1.
  - With REFRACTORY=0 the neuron may fire on consecutive cycles.
- spike_out is high for exactly one cycle per firing event. It asserts on the same edge that samples the inputs causing the crossing, so latency is 1 clock from input to spike.
- membrane_potential reads the registered pot. It shows 0 in the cycle that spike_out is high.
- A THRESHOLD above 2^POTENTIAL_WIDTH-1 means the neuron never fires. The potential then saturates at its maximum.
- THRESHOLD=0 with the clamped sum at 0 fires every integrating cycle; this is legal.
- No combinational paths from inputs to outputs.
- Simulation-only $display of the parameters at time 0 is permitted; it must not affect synthesis.

Test Plan:
1. Reset and reset mid-operation: rst_n=0 for 2 cycles, then hold input_current=6 for 2 cycles (pot 5, 10), then drop rst_n=0 → pot=0 and spike_out=0 on that edge; release and resume integrating from 0.
2. Integrate and fire (THRESHOLD=20, LEAK=1, BIAS=0, bias_signal=0): input_current=6 constant → pot 5, 10, 15, then spike_out=1 with pot=0 on the 4th edge; the pattern repeats every 4 cycles.
3. Leak and floor:
   - Input 6 for one cycle → pot=5, then input 0 → pot 4, 3, 2, 1, 0, 0 (never negative).
   - From pot=5, input_current=-9 → pot=0 immediately.
4. Dynamic bias:
   - input_current=0, bias_signal=+5 → pot 4, 8, 12, 16, then spike on the 5th edge.
   - bias_signal=4'b1000 (-8) → pot stays 0 and no spike.
5. Saturation (THRESHOLD=1000): input_current=200 → pot 199, then 255, and stays 255 with no spike.
6. Refractory (REFRACTORY=2, THRESHOLD=20): input_current=30 constant → spike on edge 1, pot 0 and spike 0 on edges 2–3, spike again on edge 4.
